// File: rtl/alu_uart_interface_if.sv
// Bundle of UART byte-stream, ALU and transmitter signals for alu_uart_interface.
// slave modport is the sequencer's view; master is the surrounding system's view.
interface alu_uart_interface_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_alu_dato_a;
    logic [NB_DATA-1:0] o_alu_dato_b;
    logic [NB_OP-1:0]   o_alu_operation;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;

    modport slave (
        input  i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        output o_alu_dato_a, o_alu_dato_b, o_alu_operation,
        output o_tx_start, o_tx_data, o_busy
    );

    modport master (
        output i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        input  o_alu_dato_a, o_alu_dato_b, o_alu_operation,
        input  o_tx_start, o_tx_data, o_busy
    );
endinterface

// File: rtl/alu_uart_interface.sv
// Frame sequencer: collects A, B, opcode bytes from UART, runs the ALU, sends the result.
// Define ALU_IF_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle clocks.
module alu_uart_interface #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    alu_uart_interface_if.slave  bus
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t             state_r,     next_state_s;
    logic [NB_DATA-1:0] dato_a_r,    dato_a_nxt_s;
    logic [NB_DATA-1:0] dato_b_r,    dato_b_nxt_s;
    logic [NB_OP-1:0]   operation_r, operation_nxt_s;
    logic [NB_DATA-1:0] tx_data_r,   tx_data_nxt_s;
    logic               tx_start_r,  tx_start_nxt_s;
    logic               busy_r,      busy_nxt_s;
    logic               timeout_s;

`ifdef ALU_IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    assign timeout_s = (state_r == WAIT_B || state_r == WAIT_OP) &&
                       (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Idle counter: runs only while a frame is partially received, cleared by any accepted byte
    always_comb begin
        cnt_nxt_s = '0;
        if ((state_r == WAIT_B || state_r == WAIT_OP) && !bus.i_rx_done && !timeout_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Idle counter register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        next_state_s    = state_r;
        dato_a_nxt_s    = dato_a_r;
        dato_b_nxt_s    = dato_b_r;
        operation_nxt_s = operation_r;
        tx_data_nxt_s   = tx_data_r;
        tx_start_nxt_s  = 1'b0;

        case (state_r)
            WAIT_A: begin
                if (bus.i_rx_done) begin
                    dato_a_nxt_s = bus.i_rx_data;
                    next_state_s = WAIT_B;
                end else begin
                    next_state_s = WAIT_A;
                end
            end
            WAIT_B: begin
                if (bus.i_rx_done) begin
                    dato_b_nxt_s = bus.i_rx_data;
                    next_state_s = WAIT_OP;
                end else if (timeout_s) begin
                    next_state_s = WAIT_A;
                end else begin
                    next_state_s = WAIT_B;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done) begin
                    operation_nxt_s = bus.i_rx_data[NB_OP-1:0];
                    next_state_s    = EXEC;
                end else if (timeout_s) begin
                    next_state_s = WAIT_A;
                end else begin
                    next_state_s = WAIT_OP;
                end
            end
            EXEC: begin
                tx_data_nxt_s  = bus.i_alu_result;
                tx_start_nxt_s = 1'b1;
                next_state_s   = WAIT_TX;
            end
            WAIT_TX: begin
                // A byte arriving here, even alongside tx_done, is dropped
                if (bus.i_tx_done) begin
                    next_state_s = WAIT_A;
                end else begin
                    next_state_s = WAIT_TX;
                end
            end
            default: begin
                next_state_s = WAIT_A;
            end
        endcase

        busy_nxt_s = (next_state_s == EXEC) || (next_state_s == WAIT_TX);
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= WAIT_A;
            dato_a_r    <= '0;
            dato_b_r    <= '0;
            operation_r <= '0;
            tx_data_r   <= '0;
            tx_start_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            dato_a_r    <= dato_a_nxt_s;
            dato_b_r    <= dato_b_nxt_s;
            operation_r <= operation_nxt_s;
            tx_data_r   <= tx_data_nxt_s;
            tx_start_r  <= tx_start_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus.o_alu_dato_a    = dato_a_r;
    assign bus.o_alu_dato_b    = dato_b_r;
    assign bus.o_alu_operation = operation_r;
    assign bus.o_tx_data       = tx_data_r;
    assign bus.o_tx_start      = tx_start_r;
    assign bus.o_busy          = busy_r;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Scoreboard bench for alu_uart_interface with a behavioural MIPS-funct ALU attached.
// Frame expectations are queued when a frame is sent and checked when o_tx_start fires.
module tb_alu_uart_interface;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
    } frame_t;

    logic   clk;
    logic   reset;
    int     checks;
    int     errors;
    frame_t exp_q[$];

    alu_uart_interface_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    alu_uart_interface #(
        .NB_DATA       (NB_DATA),
        .NB_OP         (NB_OP),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU seen by the sequencer
    always_comb begin
        case (bus.o_alu_operation)
            6'h20:   bus.i_alu_result = bus.o_alu_dato_a + bus.o_alu_dato_b;
            6'h22:   bus.i_alu_result = bus.o_alu_dato_a - bus.o_alu_dato_b;
            6'h24:   bus.i_alu_result = bus.o_alu_dato_a & bus.o_alu_dato_b;
            6'h25:   bus.i_alu_result = bus.o_alu_dato_a | bus.o_alu_dato_b;
            6'h26:   bus.i_alu_result = bus.o_alu_dato_a ^ bus.o_alu_dato_b;
            6'h27:   bus.i_alu_result = ~(bus.o_alu_dato_a | bus.o_alu_dato_b);
            6'h03:   bus.i_alu_result = $signed(bus.o_alu_dato_a) >>> bus.o_alu_dato_b;
            6'h02:   bus.i_alu_result = bus.o_alu_dato_a >> bus.o_alu_dato_b;
            default: bus.i_alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every start pulse must match the oldest outstanding frame
    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tx_start", 32'd1, 32'd0);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("sb_dato_a",    32'(bus.o_alu_dato_a),    32'(f.a));
                check("sb_dato_b",    32'(bus.o_alu_dato_b),    32'(f.b));
                check("sb_operation", 32'(bus.o_alu_operation), 32'(f.op));
                check("sb_tx_data",   32'(bus.o_tx_data),       32'(f.res));
            end
        end
    end

    // Called #1 after an edge; returns #1 after the edge that sampled the byte
    task automatic send_byte(input logic [7:0] d);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = d;
        @(posedge clk);
        #1;
        bus.i_rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dato_a"},   32'(bus.o_alu_dato_a),    32'd0);
        check({tag, "_dato_b"},   32'(bus.o_alu_dato_b),    32'd0);
        check({tag, "_op"},       32'(bus.o_alu_operation), 32'd0);
        check({tag, "_tx_data"},  32'(bus.o_tx_data),       32'd0);
        check({tag, "_tx_start"}, 32'(bus.o_tx_start),      32'd0);
        check({tag, "_busy"},     32'(bus.o_busy),          32'd0);
    endtask

    // Follows the op-byte edge: start pulse timing, busy, and tx_done handling.
    // mode 1: stray byte during WAIT_TX; mode 2: stray byte together with tx_done
    task automatic finish_frame(input logic [7:0] a, input logic [5:0] op,
                                input logic [7:0] res, input int mode);
        check("exec_busy",     32'(bus.o_busy),          32'd1);
        check("exec_tx_start", 32'(bus.o_tx_start),      32'd0);
        check("exec_op",       32'(bus.o_alu_operation), 32'(op));
        idle(1);
        check("start_pulse",   32'(bus.o_tx_start),      32'd1);
        check("start_data",    32'(bus.o_tx_data),       32'(res));
        idle(1);
        check("start_low",     32'(bus.o_tx_start),      32'd0);
        check("wait_tx_busy",  32'(bus.o_busy),          32'd1);
        if (mode == 1) begin
            send_byte(8'hAA);
            check("drop_busy",   32'(bus.o_busy),        32'd1);
            check("drop_dato_a", 32'(bus.o_alu_dato_a),  32'(a));
        end
        idle(2);
        bus.i_tx_done = 1'b1;
        if (mode == 2) begin
            bus.i_rx_done = 1'b1;
            bus.i_rx_data = 8'hAA;
        end
        @(posedge clk);
        #1;
        bus.i_tx_done = 1'b0;
        bus.i_rx_done = 1'b0;
        check("done_busy",    32'(bus.o_busy),       32'd0);
        check("held_tx_data", 32'(bus.o_tx_data),    32'(res));
        check("held_dato_a",  32'(bus.o_alu_dato_a), 32'(a));
        idle(2);
        check("hold_tx_data", 32'(bus.o_tx_data),    32'(res));
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_byte,
                             input logic [5:0] op, input logic [7:0] res, input int mode);
        exp_q.push_back('{a: a, b: b, op: op, res: res});
        send_byte(a);
        send_byte(b);
        send_byte(op_byte);
        finish_frame(a, op, res, mode);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_tx_done = 1'b0;
        idle(3);
        reset = 1'b0;
        check_all_zero("reset");

        // Stray tx_done while idle must not disturb anything
        bus.i_tx_done = 1'b1;
        idle(1);
        bus.i_tx_done = 1'b0;
        check("stray_tx_done_busy", 32'(bus.o_busy), 32'd0);

        run_frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 0);
        run_frame(8'h01, 8'h02, 8'h22, 6'h22, 8'hFF, 0);
        run_frame(8'hF0, 8'h0F, 8'h27, 6'h27, 8'h00, 1);
        run_frame(8'h06, 8'h03, 8'h24, 6'h24, 8'h02, 2);
        run_frame(8'h0C, 8'h03, 8'hE5, 6'h25, 8'h0F, 0);

        // Partial frame then reset
        send_byte(8'h11);
        send_byte(8'h22);
        check("partial_dato_b", 32'(bus.o_alu_dato_b), 32'h22);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_all_zero("midreset");
        run_frame(8'h04, 8'h04, 8'h26, 6'h26, 8'h00, 0);

        send_byte(8'h09);
        idle(20);
`ifdef ALU_IF_TIMEOUT_EN
        check("timeout_busy",   32'(bus.o_busy),       32'd0);
        check("timeout_dato_a", 32'(bus.o_alu_dato_a), 32'h09);
        run_frame(8'h02, 8'h03, 8'h20, 6'h20, 8'h05, 0);
`else
        exp_q.push_back('{a: 8'h09, b: 8'h02, op: 6'h03, res: 8'h02});
        send_byte(8'h02);
        send_byte(8'h03);
        finish_frame(8'h09, 6'h03, 8'h02, 0);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
